// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall bus arbitration, load-use detection,
// exception flush sequencing and stall/flush performance counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [4:0]  id_rs_raddr,
    input  logic [4:0]  id_rt_raddr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        excp_valid,
    input  logic [31:0] excp_pc,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_cnt
);

    localparam int unsigned STALL_W = 6;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned SC_W    = 32;
    localparam int unsigned FC_W    = 16;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_lat_q, pc_lat_d;
    logic [PC_W-1:0]   new_pc_q, new_pc_d;
    logic              flush_q, flush_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic [STALL_W-1:0] stall_c;
    logic              load_use_c;

    // Load in EX feeding a register ID is about to read; r0 never hazards.
    always_comb begin
        load_use_c = ex_is_load && (ex_rf_waddr != 5'd0) &&
                     ((id_uses_rs && (id_rs_raddr == ex_rf_waddr)) ||
                      (id_uses_rt && (id_rt_raddr == ex_rf_waddr)));
    end

    always_comb begin
        state_d  = state_q;
        pc_lat_d = pc_lat_q;
        new_pc_d = new_pc_q;
        flush_d  = 1'b0;
        stall_c  = STALL_NONE;

        case (state_q)
            ST_RUN: begin
                if (stallreq_mem)                    stall_c = STALL_MEM;
                else if (stallreq_ex)                stall_c = STALL_EX;
                else if (stallreq_id || load_use_c)  stall_c = STALL_ID;
                else if (stallreq_if)                stall_c = STALL_IF;

                if (excp_valid) begin
                    pc_lat_d = excp_pc;
                    if (stallreq_mem) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d  = ST_FLUSH;
                        flush_d  = 1'b1;
                        new_pc_d = excp_pc;
                    end
                end
            end
            // Hold everything up to MEM until the dcache releases, then flush.
            ST_DRAIN: begin
                stall_c = STALL_MEM;
                if (!stallreq_mem) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = pc_lat_q;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (cnt_clr)                              sc_d = '0;
        else if (stall_c[0] && (sc_q != '1))      sc_d = sc_q + SC_W'(1);
        else                                      sc_d = sc_q;

        if (cnt_clr)                              fc_d = '0;
        else if (flush_q)                         fc_d = fc_q + FC_W'(1);
        else                                      fc_d = fc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            pc_lat_q <= '0;
            new_pc_q <= '0;
            flush_q  <= 1'b0;
            sc_q     <= '0;
            fc_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_lat_q <= pc_lat_d;
            new_pc_q <= new_pc_d;
            flush_q  <= flush_d;
            sc_q     <= sc_d;
            fc_q     <= fc_d;
        end
    end

    assign stall        = stall_c;
    assign flush        = flush_q;
    assign new_pc       = new_pc_q;
    assign stall_cycles = sc_q;
    assign flush_cnt    = fc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        ex_is_load;
    logic [4:0]  ex_rf_waddr, id_rs_raddr, id_rt_raddr;
    logic        id_uses_rs, id_uses_rt;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_cnt;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .ex_is_load   (ex_is_load),
        .ex_rf_waddr  (ex_rf_waddr),
        .id_rs_raddr  (id_rs_raddr),
        .id_rt_raddr  (id_rt_raddr),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .excp_valid   (excp_valid),
        .excp_pc      (excp_pc),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".stall"}, 32'(stall), 32'(e.stall));
            chk({nm, ".flush"}, 32'(flush), 32'(e.flush));
            if (e.chk_pc) chk({nm, ".new_pc"}, new_pc, e.pc);
            chk({nm, ".stall_cycles"}, stall_cycles, e.sc);
            chk({nm, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
        end
    end

    task automatic idle();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        ex_is_load = 0; ex_rf_waddr = 0; id_rs_raddr = 0; id_rt_raddr = 0;
        id_uses_rs = 0; id_uses_rt = 0; excp_valid = 0; excp_pc = 0; cnt_clr = 0;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic step(input string nm, input logic [5:0] es, input logic ef,
                        input logic cp, input logic [31:0] ep,
                        input logic [31:0] esc, input logic [15:0] efc);
        exp_t e;
        e.stall = es; e.flush = ef; e.chk_pc = cp; e.pc = ep; e.sc = esc; e.fc = efc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", 6'h00, 0, 1, 32'h0, 32'd0, 16'd0);
        rst = 1'b1;
        step("idle", 6'h00, 0, 0, 32'h0, 32'd0, 16'd0);

        ex_is_load = 1; ex_rf_waddr = 5; id_rs_raddr = 5; id_uses_rs = 1;
        step("lu_rs", 6'b000111, 0, 0, 0, 32'd0, 16'd0);
        ex_rf_waddr = 0; id_rs_raddr = 0;
        step("lu_r0", 6'b000000, 0, 0, 0, 32'd1, 16'd0);
        ex_rf_waddr = 7; id_rt_raddr = 7; id_rs_raddr = 7; id_uses_rs = 0; id_uses_rt = 1;
        step("lu_rt", 6'b000111, 0, 0, 0, 32'd1, 16'd0);
        ex_rf_waddr = 9; id_rs_raddr = 9; id_rt_raddr = 3;
        step("lu_nouse", 6'b000000, 0, 0, 0, 32'd2, 16'd0);
        idle();

        stallreq_if = 1;
        step("pri_if", 6'b000011, 0, 0, 0, 32'd2, 16'd0);
        stallreq_ex = 1;
        step("pri_ex", 6'b001111, 0, 0, 0, 32'd3, 16'd0);
        stallreq_mem = 1;
        step("pri_mem", 6'b011111, 0, 0, 0, 32'd4, 16'd0);
        idle(); stallreq_id = 1;
        step("pri_id", 6'b000111, 0, 0, 0, 32'd5, 16'd0);
        idle();
        step("pri_none", 6'b000000, 0, 0, 0, 32'd6, 16'd0);

        excp_valid = 1; excp_pc = 32'hBFC00380;
        step("ex_req", 6'b000000, 0, 0, 0, 32'd6, 16'd0);
        idle(); stallreq_if = 1;
        step("ex_flush", 6'b000000, 1, 1, 32'hBFC00380, 32'd6, 16'd0);
        idle();
        step("ex_after", 6'b000000, 0, 1, 32'hBFC00380, 32'd6, 16'd1);

        stallreq_mem = 1; excp_valid = 1; excp_pc = 32'h80000180;
        step("dr_req", 6'b011111, 0, 0, 0, 32'd6, 16'd1);
        excp_pc = 32'hDEADBEEF;
        step("dr_2nd", 6'b011111, 0, 0, 0, 32'd7, 16'd1);
        excp_valid = 0; stallreq_if = 1;
        step("dr_hold", 6'b011111, 0, 0, 0, 32'd8, 16'd1);
        step("dr_hold2", 6'b011111, 0, 0, 0, 32'd9, 16'd1);
        idle();
        step("dr_release", 6'b011111, 0, 0, 0, 32'd10, 16'd1);
        step("dr_flush", 6'b000000, 1, 1, 32'h80000180, 32'd11, 16'd1);
        step("dr_after", 6'b000000, 0, 1, 32'h80000180, 32'd11, 16'd2);

        stallreq_mem = 1; excp_valid = 1; excp_pc = 32'h12345678;
        step("rs_req", 6'b011111, 0, 0, 0, 32'd11, 16'd2);
        idle(); stallreq_mem = 1;
        #2;
        rst = 1'b0;
        #1;
        stallreq_mem = 0;
        step("rs_async", 6'b000000, 0, 1, 32'h0, 32'd0, 16'd0);
        rst = 1'b1;
        step("rs_post1", 6'b000000, 0, 1, 32'h0, 32'd0, 16'd0);
        step("rs_post2", 6'b000000, 0, 1, 32'h0, 32'd0, 16'd0);

        force dut.sc_q = 32'hFFFFFFFD;
        #1;
        release dut.sc_q;
        stallreq_mem = 1;
        step("sat0", 6'b011111, 0, 0, 0, 32'hFFFFFFFD, 16'd0);
        step("sat1", 6'b011111, 0, 0, 0, 32'hFFFFFFFE, 16'd0);
        step("sat2", 6'b011111, 0, 0, 0, 32'hFFFFFFFF, 16'd0);
        step("sat3", 6'b011111, 0, 0, 0, 32'hFFFFFFFF, 16'd0);
        idle();
        step("sat4", 6'b000000, 0, 0, 0, 32'hFFFFFFFF, 16'd0);

        excp_valid = 1; excp_pc = 32'h00000400;
        step("clr_req", 6'b000000, 0, 0, 0, 32'hFFFFFFFF, 16'd0);
        idle(); cnt_clr = 1;
        step("clr_flush", 6'b000000, 1, 1, 32'h00000400, 32'hFFFFFFFF, 16'd0);
        idle();
        step("clr_after", 6'b000000, 0, 0, 0, 32'd0, 16'd0);

        force dut.fc_q = 16'hFFFF;
        #1;
        release dut.fc_q;
        excp_valid = 1; excp_pc = 32'h00000800;
        step("wrap_req", 6'b000000, 0, 0, 0, 32'd0, 16'hFFFF);
        idle();
        step("wrap_flush", 6'b000000, 1, 1, 32'h00000800, 32'd0, 16'hFFFF);
        step("wrap_after", 6'b000000, 0, 0, 0, 32'd0, 16'h0000);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
